hawk_mc_rd_arbiter: RTL

// - Shares the single memory-controller AXI read port between the HAWK read master (M0) and the CPU read master (M1).
// - Arbitrates AR requests, registers the winning AR toward the MC and tracks the owner of each outstanding burst in order.
// - Steers R beats back to that owner. Sits between hawk_axird_master / CPU slave port and the MC read bus in hacd_core.
// - Gates CPU reads with allow_cpu_rd_access from hawk_ctrl_unit.

---
 rtl/hawk_mc_rd_arbiter_pkg.sv | 18 +
 rtl/hawk_mc_rd_arbiter_if.sv | 27 ++
 rtl/hawk_mc_rd_arbiter_route_fifo.sv | 50 +++++
 rtl/hawk_mc_rd_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/hawk_mc_rd_arbiter_pkg.sv
// Shared types and constants for the HAWK/CPU memory-controller read arbiter.
package hawk_mc_rd_arbiter_pkg;

  localparam int HAWK_ADDR_W = 64;
  localparam int HAWK_ID_W   = 4;

  localparam logic HAWK_MSTR = 1'b0;
  localparam logic CPU_MSTR  = 1'b1;

  typedef struct packed {
    logic [HAWK_ADDR_W-1:0] addr;
    logic [HAWK_ID_W-1:0]   id;
    logic [7:0]             len;
  } hawk_ar_req_t;

  typedef enum logic {ARB_IDLE, ARB_ISSUE} arb_state_t;

endpackage

// File: rtl/hawk_mc_rd_arbiter_if.sv
// AXI read (AR + R) channel bundle; master drives AR and rready, slave drives arready and R.
interface hawk_mc_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arid, arlen, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/hawk_mc_rd_arbiter_route_fifo.sv
// hawk_rd_route_fifo: 1-bit owner FIFO recording which master each outstanding burst belongs to.
module hawk_rd_route_fifo #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/hawk_mc_rd_arbiter.sv
// Shares the MC AXI read port between HAWK (m0) and CPU (m1); R beats steered by an in-order owner FIFO.
// HAWK_RD_ARB_RR_EN selects round-robin arbitration; otherwise HAWK has fixed priority.
module hawk_mc_rd_arbiter
  import hawk_mc_rd_arbiter_pkg::*;
#(
  parameter  int ADDR_W   = HAWK_ADDR_W,
  parameter  int DATA_W   = 512,
  parameter  int ID_W     = HAWK_ID_W,
  parameter  int MAX_OUTS = 8,
  localparam int CNT_W    = $clog2(MAX_OUTS) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   allow_cpu_rd_access,
  hawk_mc_rd_arbiter_if.slave    m0,
  hawk_mc_rd_arbiter_if.slave    m1,
  hawk_mc_rd_arbiter_if.master   mc,
  output logic [CNT_W-1:0]       outs_cnt
);

  arb_state_t        state_q, state_d;
  hawk_ar_req_t      ar_q, win_req;
  logic              owner_q;
  logic [1:0]        elig;
  logic              winner, grant, push, pop;
  logic [ADDR_W-1:0] win_addr;
  logic [ID_W-1:0]   win_id;
  logic [DATA_W-1:0] rdata_bc;
  logic              head, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign elig = {m1.arvalid & allow_cpu_rd_access, m0.arvalid};

`ifdef HAWK_RD_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)    last_grant <= CPU_MSTR;
    else if (grant) last_grant <= winner;
  end

  always_comb begin
    winner = elig[0] ? HAWK_MSTR : CPU_MSTR;
    if (&elig) winner = ~last_grant;
  end
`else
  always_comb winner = elig[0] ? HAWK_MSTR : CPU_MSTR;
`endif

  assign win_addr = (winner == CPU_MSTR) ? m1.araddr : m0.araddr;
  assign win_id   = (winner == CPU_MSTR) ? m1.arid   : m0.arid;

  always_comb begin
    win_req.addr = win_addr;
    win_req.id   = win_id;
    win_req.len  = (winner == CPU_MSTR) ? m1.arlen : m0.arlen;
  end

  // Arbitration only happens in IDLE, so at most one AR every two cycles
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    push       = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|elig && !fifo_full) begin
          grant   = 1'b1;
          state_d = ARB_ISSUE;
          if (winner == CPU_MSTR) m1.arready = 1'b1;
          else                    m0.arready = 1'b1;
        end
      end
      ARB_ISSUE: begin
        if (mc.arready) begin
          push    = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      ar_q    <= '0;
      owner_q <= HAWK_MSTR;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ar_q    <= win_req;
        owner_q <= winner;
      end
    end
  end

  assign mc.arvalid = (state_q == ARB_ISSUE);
  assign mc.araddr  = ar_q.addr;
  assign mc.arid    = ar_q.id;
  assign mc.arlen   = ar_q.len;

  hawk_rd_route_fifo #(.DEPTH(MAX_OUTS)) u_route_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .din   (owner_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign outs_cnt = fifo_count;

  // With no outstanding burst nobody owns R, so the MC is held off
  assign mc.rready = !fifo_empty && ((head == CPU_MSTR) ? m1.rready : m0.rready);
  assign m0.rvalid = !fifo_empty && (head == HAWK_MSTR) && mc.rvalid;
  assign m1.rvalid = !fifo_empty && (head == CPU_MSTR)  && mc.rvalid;
  assign pop       = mc.rvalid & mc.rready & mc.rlast;

  assign rdata_bc  = mc.rdata;
  assign m0.rdata  = rdata_bc;
  assign m1.rdata  = rdata_bc;
  assign m0.rresp  = mc.rresp;
  assign m1.rresp  = mc.rresp;
  assign m0.rlast  = mc.rlast;
  assign m1.rlast  = mc.rlast;

endmodule
